vs_spi_arbiter: RTL and testbench
=================================

// Module: vs_spi_arbiter
// PURPOSE
// - Shares the single VS1003 SPI bus between two requesters:
//   - SCI register writes: volume/mode updates from the control path.
//   - SDI audio byte stream from the mp3 data fetcher.
// - Gates all traffic on DREQ, arbitrates SCI vs SDI without starvation, and drives SCK/SI/XCS/XDCS directly.
// - Sits between the mp3 sequencing logic and the codec pins.
// PARAMETERS
// - CLK_DIV    4   clk cycles per SCK half-period (>=2)
// - SDI_BURST  32  max SDI bytes per grant (VS1003 guarantees 32 bytes of room while DREQ=1)
// PORTS
// - clk          in   1   system clock, all logic on rising edge
// - rst          in   1   synchronous, active-high reset
// - i_DREQ       in   1   codec data request; async, 2-flop synchronised inside
// - i_sci_req    in   1   SCI write request; level, held until o_sci_ack
// - i_sci_addr   in   8   SCI register address, captured at grant
// - i_sci_wdata  in   16  SCI write data, captured at grant
// - o_sci_ack    out  1   1-cycle pulse: SCI frame complete
// - i_sdi_valid  in   1   SDI byte available
// - i_sdi_data   in   8   SDI byte
// - o_sdi_ready  out  1   byte taken this cycle when i_sdi_valid=1
// - o_SCK        out  1   SPI clock, mode 0, idles low
// - o_SI         out  1   SPI data, MSB first
// - o_XCS        out  1   SCI chip select, active low
// - o_XDCS       out  1   SDI chip select, active low
// - o_busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
// - Reset values: o_SCK=0, o_SI=0, o_XCS=1, o_XDCS=1, o_sci_ack=0, o_sdi_ready=0, o_busy=0, last_sci=0.
// - Reset mid-frame: frame abandoned, no ack, bus idle on the next edge.
// - Bit timing:
//   - SI is updated with SCK low; SCK high for CLK_DIV cycles, then low for CLK_DIV.
//   - One bit = 2*CLK_DIV clks.
// - States: IDLE, SCI_SETUP, SCI_SHIFT, SCI_HOLD, SDI_SETUP, SDI_SHIFT, SDI_NEXT, SDI_HOLD.
// - Grant is decided in IDLE only, and only when synced DREQ=1:
//   - sci_req && !(last_sci && sdi_valid) -> SCI_SETUP; sets last_sci=1.
//   - else if sdi_valid -> SDI_SETUP; clears last_sci.
//   - SCI wins when both are pending, but never twice in a row while SDI is waiting.
//   - Grant happens in the same cycle as the decision.
// - SCI frame:
//   - 32 bits: 0x02, addr[7:0], wdata[15:0].
//   - XCS goes low at SETUP; first SCK rise comes CLK_DIV clks later.
//   - After bit 0, HOLD keeps XCS low for CLK_DIV clks, then XCS=1.
//   - o_sci_ack pulses in the cycle XCS rises; return to IDLE.
// - SDI burst:
//   - XDCS goes low at SETUP. o_sdi_ready=1 for exactly one cycle at SETUP and at each SDI_NEXT.
//   - If valid=1 in that cycle, the byte is latched and shifted (8 bits); count is incremented.
//   - If valid=0 at NEXT, or count==SDI_BURST, go to HOLD: XDCS stays low CLK_DIV clks, then 1, then IDLE.
//   - DREQ falling mid-burst is ignored; bursts are bounded by SDI_BURST.
// - XCS and XDCS are never low simultaneously; at least CLK_DIV idle clks between frames.
// - Byte counter width is $clog2(SDI_BURST+1); bit counter is 5 bits; divider counter is $clog2(CLK_DIV).
// - sci_req dropped before grant: no frame. Changes after grant: ignored (data already captured).
// CONFIGURATION
// - Macro VS_SCI_READ_EN enables SCI reads.
// - When defined, adds ports:
//   - i_SO        in   1   codec serial out
//   - i_sci_rd    in   1   read request, sampled with i_sci_req
//   - o_sci_rdata out  16  read result
// - Read frame:
//   - Opcode 0x03 + addr; the 16 data bits are sampled from i_SO on SCK rising edges.
//   - o_sci_rdata is valid in the o_sci_ack cycle and held until the next read; reset value 0.
// - Undefined: ports absent, all SCI frames are writes, opcode is always 0x02.
// TESTING
// - Reset then idle, DREQ=1, no requests -> XCS=XDCS=1, SCK=0, o_busy=0 for 100 clks.
// - SCI write addr=0x0B data=0x2020, CLK_DIV=4 -> SI shows 0x020B2020 MSB first.
//   - Exactly 32 SCK pulses, 8 clks each.
//   - o_sci_ack one pulse; XDCS stays 1 throughout.
// - SDI: 40 valid bytes 0x00..0x27, DREQ=1 -> first burst 32 bytes, XDCS high, then 8 bytes.
//   - Check the SI byte stream matches the input stream.
// - SCI and SDI both pending, with the SCI request re-asserted after each ack -> order is SCI, SDI burst, SCI, SDI burst.
//   - No back-to-back SCI while SDI valid is held.
// - DREQ=0 with both requests pending -> no chip select asserted.
//   - DREQ raised -> grant within 3 clks (sync latency).
// - rst pulsed mid-SCI frame (bit 12) -> next cycle XCS=1, SCK=0, no ack.
//   - A re-held request produces a full 32-bit frame afterwards.

Source files
------------

// File: rtl/vs_spi_arbiter.sv
// vs_spi_arbiter: shares the VS1003 SPI bus between SCI register writes and
// the SDI audio byte stream. All traffic is gated on the synchronised DREQ.
// SCI wins a tie but never twice in a row while SDI is waiting.
// SPI mode 0: SI changes while SCK is low, SCK high for CLK_DIV clks then low
// for CLK_DIV clks. At least CLK_DIV idle clks separate consecutive frames.
// Optional feature: define VS_SCI_READ_EN to add SCI register reads
// (ports i_SO, i_sci_rd, o_sci_rdata; opcode 0x03, data sampled on SCK rise).
// Handshakes: i_sci_req is a level held until the one-cycle o_sci_ack pulse;
// an SDI byte moves in the cycle where o_sdi_ready and i_sdi_valid are both 1.
module vs_spi_arbiter #(
    parameter int CLK_DIV   = 4,
    parameter int SDI_BURST = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_DREQ,
    input  logic        i_sci_req,
    input  logic [7:0]  i_sci_addr,
    input  logic [15:0] i_sci_wdata,
    output logic        o_sci_ack,
    input  logic        i_sdi_valid,
    input  logic [7:0]  i_sdi_data,
    output logic        o_sdi_ready,
    output logic        o_SCK,
    output logic        o_SI,
    output logic        o_XCS,
    output logic        o_XDCS,
`ifdef VS_SCI_READ_EN
    input  logic        i_SO,
    input  logic        i_sci_rd,
    output logic [15:0] o_sci_rdata,
`endif
    output logic        o_busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(SDI_BURST + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(SDI_BURST);

    typedef enum logic [2:0] {
        IDLE, SCI_SETUP, SCI_SHIFT, SCI_HOLD,
        SDI_SETUP, SDI_SHIFT, SDI_NEXT, SDI_HOLD
    } state_t;

    state_t          state;
    logic [1:0]      dreq_sync;
    logic            last_sci;
    logic [DW-1:0]   div;
    logic [4:0]      bit_cnt;
    logic [CW-1:0]   byte_cnt;
    logic [31:0]     shreg;
    logic [7:0]      sci_opcode;
    logic [31:0]     sci_word;
    logic            dreq_s;
    logic            div_done;

`ifdef VS_SCI_READ_EN
    logic            rd_op;
    logic [15:0]     rd_sh;
    assign sci_opcode = i_sci_rd ? 8'h03 : 8'h02;
`else
    assign sci_opcode = 8'h02;
`endif

    assign sci_word = {sci_opcode, i_sci_addr, i_sci_wdata};
    assign dreq_s   = dreq_sync[1];
    assign div_done = (div == DIV_LAST);
    assign o_busy   = (state != IDLE);

    // Arbitration, frame sequencing and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dreq_sync   <= 2'b00;
            last_sci    <= 1'b0;
            div         <= '0;
            bit_cnt     <= 5'd0;
            byte_cnt    <= '0;
            shreg       <= 32'd0;
            o_SCK       <= 1'b0;
            o_SI        <= 1'b0;
            o_XCS       <= 1'b1;
            o_XDCS      <= 1'b1;
            o_sci_ack   <= 1'b0;
            o_sdi_ready <= 1'b0;
`ifdef VS_SCI_READ_EN
            rd_op       <= 1'b0;
            rd_sh       <= 16'd0;
            o_sci_rdata <= 16'd0;
`endif
        end else begin
            dreq_sync   <= {dreq_sync[0], i_DREQ};
            o_sci_ack   <= 1'b0;
            o_sdi_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // div doubles as the inter-frame idle timer here.
                    if (!div_done) begin
                        div <= div + DW'(1);
                    end else if (dreq_s && i_sci_req && !(last_sci && i_sdi_valid)) begin
                        state    <= SCI_SETUP;
                        o_XCS    <= 1'b0;
                        last_sci <= 1'b1;
                        div      <= '0;
                        bit_cnt  <= 5'd31;
                        shreg    <= sci_word;
                        o_SI     <= sci_word[31];
`ifdef VS_SCI_READ_EN
                        rd_op    <= i_sci_rd;
`endif
                    end else if (dreq_s && i_sdi_valid) begin
                        state       <= SDI_SETUP;
                        o_XDCS      <= 1'b0;
                        last_sci    <= 1'b0;
                        div         <= '0;
                        byte_cnt    <= '0;
                        o_sdi_ready <= 1'b1;
                    end
                end
                SCI_SETUP: begin
                    if (div_done) begin
                        o_SCK <= 1'b1;
                        div   <= '0;
                        state <= SCI_SHIFT;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                SCI_SHIFT, SDI_SHIFT: begin
                    if (!div_done) begin
                        div <= div + DW'(1);
                    end else begin
                        div   <= '0;
                        o_SCK <= !o_SCK;
                        if (o_SCK) begin
                            if (bit_cnt == 5'd0) begin
                                o_SI <= 1'b0;
                                if (state == SCI_SHIFT) begin
                                    state <= SCI_HOLD;
                                end else if (byte_cnt == BURST_MAX) begin
                                    state <= SDI_HOLD;
                                end else begin
                                    state       <= SDI_NEXT;
                                    o_sdi_ready <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                                shreg   <= shreg << 1;
                                o_SI    <= shreg[30];
                            end
                        end else begin
`ifdef VS_SCI_READ_EN
                            if (state == SCI_SHIFT && rd_op && bit_cnt < 5'd16)
                                rd_sh <= {rd_sh[14:0], i_SO};
`endif
                        end
                    end
                end
                SCI_HOLD: begin
                    if (div_done) begin
                        o_XCS     <= 1'b1;
                        o_sci_ack <= 1'b1;
                        div       <= '0;
                        state     <= IDLE;
`ifdef VS_SCI_READ_EN
                        if (rd_op) o_sci_rdata <= rd_sh;
`endif
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                SDI_SETUP: begin
                    // First cycle is the handshake; the remaining CLK_DIV-1
                    // cycles complete the low phase before the first rise.
                    if (o_sdi_ready) begin
                        if (i_sdi_valid) begin
                            shreg    <= {i_sdi_data, 24'd0};
                            o_SI     <= i_sdi_data[7];
                            byte_cnt <= byte_cnt + CW'(1);
                            bit_cnt  <= 5'd7;
                            div      <= DW'(1);
                        end else begin
                            div   <= '0;
                            state <= SDI_HOLD;
                        end
                    end else if (div_done) begin
                        o_SCK <= 1'b1;
                        div   <= '0;
                        state <= SDI_SHIFT;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                SDI_NEXT: begin
                    if (i_sdi_valid) begin
                        shreg    <= {i_sdi_data, 24'd0};
                        o_SI     <= i_sdi_data[7];
                        byte_cnt <= byte_cnt + CW'(1);
                        bit_cnt  <= 5'd7;
                        div      <= DW'(1);
                        state    <= SDI_SETUP;
                    end else begin
                        div   <= '0;
                        state <= SDI_HOLD;
                    end
                end
                SDI_HOLD: begin
                    if (div_done) begin
                        o_XDCS <= 1'b1;
                        div    <= '0;
                        state  <= IDLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vs_spi_arbiter.sv
// Bench for vs_spi_arbiter: a bus-level model decodes SCK/SI per chip select
// and compares frames against expected queues every cycle.
module tb_vs_spi_arbiter;

    localparam int CLK_DIV   = 4;
    localparam int SDI_BURST = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b0;
    logic        sci_req = 1'b0;
    logic [7:0]  sci_addr = 8'd0;
    logic [15:0] sci_wdata = 16'd0;
    logic        sdi_valid = 1'b0;
    logic [7:0]  sdi_data = 8'd0;
    logic        ack, ready, sck, si, xcs, xdcs, busy;
`ifdef VS_SCI_READ_EN
    logic        so_tie = 1'b0;
    logic        rd_tie = 1'b0;
    logic [15:0] rdata;
`endif

    vs_spi_arbiter #(.CLK_DIV(CLK_DIV), .SDI_BURST(SDI_BURST)) dut (
        .clk(clk), .rst(rst), .i_DREQ(dreq),
        .i_sci_req(sci_req), .i_sci_addr(sci_addr), .i_sci_wdata(sci_wdata),
        .o_sci_ack(ack), .i_sdi_valid(sdi_valid), .i_sdi_data(sdi_data),
        .o_sdi_ready(ready), .o_SCK(sck), .o_SI(si), .o_XCS(xcs), .o_XDCS(xdcs),
`ifdef VS_SCI_READ_EN
        .i_SO(so_tie), .i_sci_rd(rd_tie), .o_sci_rdata(rdata),
`endif
        .o_busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard state
    logic [31:0] exp_sci_q[$];
    logic [7:0]  exp_sdi_q[$];
    logic [7:0]  src_q[$];
    int          event_log[$];   // 0 = SCI frame, n>0 = SDI burst of n bytes

    logic        prev_sck = 1'b0, prev_xcs = 1'b1, prev_xdcs = 1'b1, prev_cs = 1'b0;
    logic        rst_d = 1'b1;
    logic [31:0] sci_word = 32'd0, last_sci_word = 32'd0;
    logic [7:0]  sdi_byte = 8'd0;
    int          sci_nbits = 0, sdi_nbits = 0, burst_bytes = 0;
    int          hi_run = 0, lo_run = 0, gap_run = 0;
    int          sck_rises = 0, ack_count = 0, xdcs_low_cycles = 0, aborts = 0;

    // compare process: decode the bus and check protocol rules every cycle
    initial begin : monitor
        logic cs_any, xcs_rise, xdcs_rise;
        logic [31:0] e32;
        logic [7:0]  e8;
        forever begin
            @(negedge clk);
            cs_any = (xcs == 1'b0) || (xdcs == 1'b0);
            if (rst_d) begin
                check("rst_xcs", 32'(xcs), 32'd1);
                check("rst_xdcs", 32'(xdcs), 32'd1);
                check("rst_sck", 32'(sck), 32'd0);
                check("rst_si", 32'(si), 32'd0);
                check("rst_ack", 32'(ack), 32'd0);
                check("rst_ready", 32'(ready), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                if (!prev_xcs) begin
                    if (exp_sci_q.size() > 0) void'(exp_sci_q.pop_front());
                    aborts++;
                end
                sci_nbits = 0; sdi_nbits = 0; burst_bytes = 0;
                hi_run = 0; lo_run = 0; gap_run = 1;
            end else begin
                xcs_rise  = !prev_xcs && xcs;
                xdcs_rise = !prev_xdcs && xdcs;
                check("cs_exclusive", 32'(xcs | xdcs), 32'd1);
                if (!cs_any) check("sck_idle", 32'(sck), 32'd0);
                else         check("busy_in_frame", 32'(busy), 32'd1);
                if (ready) check("ready_needs_xdcs", 32'(xdcs), 32'd0);
                check("ack_at_xcs_rise", 32'(ack), 32'(xcs_rise));
                if (ack) ack_count++;
                if (!xdcs) xdcs_low_cycles++;
                if (cs_any && !prev_cs) begin
                    check("idle_gap", 32'(gap_run >= CLK_DIV), 32'd1);
                    lo_run = 0;
                end
                if (sck && !prev_sck) begin
                    check("sck_low_len", 32'(lo_run), 32'(CLK_DIV));
                    hi_run = 0;
                    sck_rises++;
                    if (!xcs) begin
                        sci_word = {sci_word[30:0], si};
                        sci_nbits++;
                    end else if (!xdcs) begin
                        sdi_byte = {sdi_byte[6:0], si};
                        sdi_nbits++;
                        if (sdi_nbits == 8) begin
                            sdi_nbits = 0;
                            burst_bytes++;
                            check("sdi_expected", 32'(exp_sdi_q.size() > 0), 32'd1);
                            if (exp_sdi_q.size() > 0) begin
                                e8 = exp_sdi_q.pop_front();
                                check("sdi_byte", 32'(sdi_byte), 32'(e8));
                            end
                        end
                    end
                end
                if (!sck && prev_sck) begin
                    check("sck_high_len", 32'(hi_run), 32'(CLK_DIV));
                    lo_run = 0;
                end
                if (xcs_rise) begin
                    check("sci_bits", 32'(sci_nbits), 32'd32);
                    check("sci_cs_hold", 32'(lo_run >= CLK_DIV), 32'd1);
                    check("sci_expected", 32'(exp_sci_q.size() > 0), 32'd1);
                    if (exp_sci_q.size() > 0) begin
                        e32 = exp_sci_q.pop_front();
                        check("sci_frame", sci_word, e32);
                    end
                    last_sci_word = sci_word;
                    event_log.push_back(0);
                    sci_nbits = 0;
                end
                if (xdcs_rise) begin
                    check("sdi_whole_bytes", 32'(sdi_nbits), 32'd0);
                    check("sdi_cs_hold", 32'(lo_run >= CLK_DIV), 32'd1);
                    event_log.push_back(burst_bytes);
                    burst_bytes = 0;
                end
                if (sck) hi_run++;
                else if (cs_any) lo_run++;
                if (cs_any) gap_run = 0;
                else gap_run++;
            end
            prev_sck = sck; prev_xcs = xcs; prev_xdcs = xdcs; prev_cs = cs_any;
            rst_d = rst;
        end
    end

    // SDI source driver: presents src_q front, pops on handshake
    initial begin : sdi_source
        logic took;
        forever begin
            @(negedge clk);
            took = ready && sdi_valid;
            @(posedge clk);
            #1;
            if (took && src_q.size() > 0) void'(src_q.pop_front());
            sdi_valid = (src_q.size() > 0);
            sdi_data  = (src_q.size() > 0) ? src_q[0] : 8'd0;
        end
    end

    task automatic wait_ack(input int limit);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (ack) seen = 1'b1;
        end
        check("ack_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic sci_write(input logic [7:0] addr, input logic [15:0] data, input int limit);
        exp_sci_q.push_back({8'h02, addr, data});
        @(posedge clk); #1;
        sci_addr = addr; sci_wdata = data; sci_req = 1'b1;
        wait_ack(limit);
        @(posedge clk); #1;
        sci_req = 1'b0;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) begin
            src_q.push_back(first + 8'(i));
            exp_sdi_q.push_back(first + 8'(i));
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(src_q.size() == 0 && !busy && !sci_req) && n < limit);
        check("idle_within_budget", 32'(n < limit), 32'd1);
    endtask

    initial begin : stimulus
        int acks0, rises0, xdlow0, base, bad_cycles, k, aborts0;
        bit  hit;

        // reset, then idle with DREQ high
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; dreq = 1'b1;
        bad_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (!xcs || !xdcs || sck || busy) bad_cycles++;
        end
        check("idle_100_clks", 32'(bad_cycles), 32'd0);

        // single SCI write
        acks0 = ack_count; rises0 = sck_rises; xdlow0 = xdcs_low_cycles;
        sci_write(8'h0B, 16'h2020, 2000);
        repeat (20) @(posedge clk);
        check("sci_word_literal", last_sci_word, 32'h020B2020);
        check("sci_pulse_count", 32'(sck_rises - rises0), 32'd32);
        check("sci_ack_count", 32'(ack_count - acks0), 32'd1);
        check("sci_xdcs_quiet", 32'(xdcs_low_cycles - xdlow0), 32'd0);

        // 40 SDI bytes -> bursts of 32 then 8
        base = event_log.size();
        push_bytes(8'h00, 40);
        wait_idle(10000);
        check("sdi_burst_count", 32'(event_log.size() - base), 32'd2);
        if (event_log.size() >= base + 2) begin
            check("sdi_burst0_len", 32'(event_log[base]), 32'd32);
            check("sdi_burst1_len", 32'(event_log[base + 1]), 32'd8);
        end
        check("sdi_all_seen", 32'(exp_sdi_q.size()), 32'd0);

        // DREQ low with both pending, then fairness order
        @(posedge clk); #1 dreq = 1'b0;
        repeat (5) @(posedge clk);
        base = event_log.size();
        push_bytes(8'h80, 40);
        fork
            begin
                sci_write(8'h03, 16'h1234, 6000);
                sci_write(8'h0A, 16'hBEEF, 6000);
            end
            begin
                bad_cycles = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (!xcs || !xdcs) bad_cycles++;
                end
                check("dreq_low_blocks", 32'(bad_cycles), 32'd0);
                @(posedge clk); #1 dreq = 1'b1;
                k = 0; hit = 1'b0;
                while (!hit && k < 20) begin
                    @(posedge clk); k++;
                    @(negedge clk);
                    if (!xcs || !xdcs) hit = 1'b1;
                end
                check("dreq_grant_seen", 32'(hit), 32'd1);
                check("dreq_grant_latency", 32'(k <= 3), 32'd1);
            end
        join
        wait_idle(10000);
        check("order_events", 32'(event_log.size() - base), 32'd4);
        if (event_log.size() >= base + 4) begin
            check("order_0_sci", 32'(event_log[base]), 32'd0);
            check("order_1_sdi", 32'(event_log[base + 1]), 32'd32);
            check("order_2_sci", 32'(event_log[base + 2]), 32'd0);
            check("order_3_sdi", 32'(event_log[base + 3]), 32'd8);
        end

        // reset in the middle of an SCI frame, request still held
        acks0 = ack_count; aborts0 = aborts;
        exp_sci_q.push_back(32'h0205A5C3);
        @(posedge clk); #1;
        sci_addr = 8'h05; sci_wdata = 16'hA5C3; sci_req = 1'b1;
        k = 0;
        while (sci_nbits != 12 && k < 1000) begin
            @(negedge clk); k++;
        end
        check("reached_bit12", 32'(sci_nbits), 32'd12);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_sci_q.push_back(32'h0205A5C3);
        @(negedge clk);
        check("abort_xcs", 32'(xcs), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        wait_ack(2000);
        @(posedge clk); #1 sci_req = 1'b0;
        repeat (20) @(posedge clk);
        check("abort_count", 32'(aborts - aborts0), 32'd1);
        check("refr_ack_count", 32'(ack_count - acks0), 32'd1);
        check("refr_word_literal", last_sci_word, 32'h0205A5C3);
        check("sci_all_seen", 32'(exp_sci_q.size()), 32'd0);
        check("sdi_all_seen_end", 32'(exp_sdi_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case a bounded wait is itself never reached
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
